// File: rtl/touch_pulse_gen_if.sv
// touch_pulse_gen_if: start/press_num request and touch_out/busy/done status of the touch pulse generator
interface touch_pulse_gen_if #(parameter int NUM_W = 4);
  logic             start;
  logic [NUM_W-1:0] press_num;
  logic             touch_out;
  logic             busy;
  logic             done;
  modport master (output start, press_num, input touch_out, busy, done);
  modport slave  (input start, press_num, output touch_out, busy, done);
endinterface

// File: rtl/touch_pulse_gen.sv
// touch_pulse_gen: bursts of synthetic active-low touch presses; contact bounce emulation enabled by TOUCH_PULSE_GEN_BOUNCE_EN
module touch_pulse_gen #(
  parameter int CNT_W     = 16,
  parameter int PRESS_CYC = 50,
  parameter int GAP_CYC   = 50,
  parameter int NUM_W     = 4
) (
  input logic              sys_clk,
  input logic              sys_rst_n,
  touch_pulse_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;
  localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(PRESS_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [NUM_W-1:0] rem, rem_n;
  logic             touch_q, touch_n, busy_q, busy_n, done_q, done_n, bounce_lvl;
  assign cnt_inc = cnt + CNT_W'(1);
`ifdef TOUCH_PULSE_GEN_BOUNCE_EN
  // level for the upcoming press cycle: high on cnt 1 and 3 gives 0,1,0,1 then steady low
  assign bounce_lvl = (cnt_inc == CNT_W'(1)) || (cnt_inc == CNT_W'(3));
  if (PRESS_CYC < 8) begin : g_bad_cfg
    $error("touch_pulse_gen: PRESS_CYC must be >= 8 when bounce emulation is enabled");
  end
`else
  assign bounce_lvl = 1'b0;
`endif
  assign bus.touch_out = touch_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rem     <= '0;
      touch_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rem     <= rem_n;
      touch_q <= touch_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rem_n   = rem;
    touch_n = touch_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    case (state)
      IDLE:
        if (bus.start) begin
          if (bus.press_num != '0) begin
            state_n = PRESS;
            rem_n   = bus.press_num;
            touch_n = 1'b0;
            busy_n  = 1'b1;
            cnt_n   = '0;
          end else done_n = 1'b1;
        end
      PRESS:
        if (cnt == PRESS_LAST) begin
          state_n = GAP;
          cnt_n   = '0;
          rem_n   = rem - NUM_W'(1);
          touch_n = 1'b1;
        end else begin
          cnt_n   = cnt_inc;
          touch_n = bounce_lvl;
        end
      GAP:
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          state_n = rem != '0 ? PRESS : IDLE;
          touch_n = rem == '0;
          busy_n  = rem != '0;
          done_n  = rem == '0;
        end else cnt_n = cnt_inc;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_touch_pulse_gen.sv
// tb_touch_pulse_gen: scoreboard bench comparing touch_out/busy/done each cycle against an arithmetic burst model
module tb_touch_pulse_gen;
`ifdef TOUCH_PULSE_GEN_BOUNCE_EN
  localparam int P = 8;
  localparam bit BNC = 1'b1;
`else
  localparam int P = 4;
  localparam bit BNC = 1'b0;
`endif
  localparam int G = 3;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e0 = 0;
  int blen = 0;
  int end_e = -1;
  int done_q[$];
  touch_pulse_gen_if #(.NUM_W(4)) tif();
  touch_pulse_gen #(.CNT_W(16), .PRESS_CYC(P), .GAP_CYC(G), .NUM_W(4)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(tif)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d, t=%0t)", nm, act, exp, cyc, $time);
    end
  endtask
  function automatic logic exp_touch(input int t);
    int ph;
    ph = t % (P + G);
    if (ph >= P) return 1'b1;
    return BNC && (ph == 1 || ph == 3);
  endfunction
  // reference: a burst accepted at edge e0 spans press_num*(P+G) edges and ends with done at e0+len
  always @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      e0    <= 0;
      blen  <= 0;
      end_e <= cyc;
      done_q.delete();
    end else begin
      cyc <= cyc + 1;
      if (tif.start && cyc + 1 > end_e) begin
        e0    <= cyc + 1;
        blen  <= int'(tif.press_num) * (P + G);
        end_e <= cyc + 1 + int'(tif.press_num) * (P + G);
        done_q.push_back(cyc + 1 + int'(tif.press_num) * (P + G));
      end
    end
  always @(negedge sys_clk) begin
    int t;
    logic eb, ed;
    t  = cyc - e0;
    eb = t >= 0 && t < blen;
    chk("touch_out", tif.touch_out, eb ? exp_touch(t) : 1'b1);
    chk("busy", tif.busy, eb);
    ed = done_q.size() > 0 && done_q[0] == cyc;
    chk("done", tif.done, ed);
    while (done_q.size() > 0 && done_q[0] <= cyc) void'(done_q.pop_front());
  end
  task automatic pulse(input int n);
    @(negedge sys_clk);
    tif.start = 1'b1;
    tif.press_num = 4'(n);
    @(negedge sys_clk);
    tif.start = 1'b0;
  endtask
  task automatic wait_done();
    for (int k = 0; k < 400 && tif.done !== 1'b1; k++) @(negedge sys_clk);
    if (tif.done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=%0b required 1 within 400 cycles", tif.done);
    end
  endtask
  task automatic wait_idle();
    for (int k = 0; k < 400 && tif.busy !== 1'b0; k++) @(negedge sys_clk);
    if (tif.busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=%0b required 0 within 400 cycles", tif.busy);
    end
  endtask
  initial begin
    tif.start = 1'b1;
    tif.press_num = 4'd5;
    repeat (4) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    tif.start = 1'b0;
    repeat (3) @(negedge sys_clk);
    pulse(1);
    wait_done();
    repeat (2) @(negedge sys_clk);
    pulse(3);
    repeat (5) @(negedge sys_clk);
    tif.start = 1'b1;
    tif.press_num = 4'd7;
    @(negedge sys_clk);
    tif.start = 1'b0;
    tif.press_num = 4'd1;
    wait_done();
    tif.start = 1'b1;
    tif.press_num = 4'd2;
    @(negedge sys_clk);
    tif.start = 1'b0;
    wait_done();
    pulse(0);
    wait_done();
    pulse(15);
    wait_done();
    repeat (600) begin
      @(negedge sys_clk);
      tif.start = $urandom_range(0, 7) == 0;
      tif.press_num = 4'($urandom_range(0, 15));
    end
    tif.start = 1'b0;
    wait_idle();
    pulse(2);
    @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async_rst_touch", tif.touch_out, 1'b1);
    chk("async_rst_busy", tif.busy, 1'b0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (10) @(negedge sys_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/touch_pulse_gen.md
Name: touch_pulse_gen

Overview:
- Transmit side of the touch-key interface: generates synthetic active-low touch presses on touch_out.
- Output drives the touch-key input of the LED toggle logic for self-test and demo builds, standing in for the physical sensor.
- A start request triggers a burst of press_num presses. Each press is low for PRESS_CYC cycles, followed by a high gap of GAP_CYC cycles.

Parameters:
- CNT_W, 16, width of the internal duration counter; PRESS_CYC and GAP_CYC must be <= 2^CNT_W-1.
- PRESS_CYC, 50, cycles touch_out is held low per press; must be >= 1 (>= 8 when BOUNCE_EN is defined).
- GAP_CYC, 50, cycles touch_out is held high after each press; must be >= 1.
- NUM_W, 4, width of press_num.

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- press_num  in  NUM_W  number of presses in the burst; latched when start is accepted.
- touch_out  out  1  emulated touch key, active low, registered, idle 1.
- busy  out  1  high while a burst is in progress (PRESS/GAP states).
- done  out  1  one-cycle pulse marking burst completion.

Behaviour:
- Reset (async, immediate): touch_out=1, busy=0, done=0, state=IDLE, counters=0. Reset mid-burst aborts it; no done pulse.
- States: IDLE, PRESS, GAP. All outputs registered.
- IDLE, start=1, press_num!=0, at edge E0:
  - latch press_num into remaining; state<=PRESS; touch_out<=0; busy<=1; cnt<=0.
- IDLE, start=1, press_num==0: at the next edge done<=1 for one cycle. No press generated; busy stays 0.
- PRESS: cnt increments each cycle. At the edge where cnt==PRESS_CYC-1:
  - touch_out<=1, state<=GAP, cnt<=0, remaining decrements.
  - touch_out is therefore low for exactly PRESS_CYC cycles (edges E0 .. E0+PRESS_CYC).
- GAP: cnt increments. At the edge where cnt==GAP_CYC-1:
  - if remaining!=0: state<=PRESS, touch_out<=0, cnt<=0.
  - else: state<=IDLE, busy<=0, done<=1 for exactly one cycle.
- Burst length: press_num*(PRESS_CYC+GAP_CYC) cycles from E0 to the done edge.
- start while busy=1 is ignored; press_num changes mid-burst have no effect.
- start in the cycle done is high is accepted (state is already IDLE); back-to-back bursts are allowed.
- press_num at its maximum value (2^NUM_W-1) must be supported without wrap.
- The counter never exceeds max(PRESS_CYC, GAP_CYC)-1; no wrap-around.

Optional Feature:
- Macro: TOUCH_PULSE_GEN_BOUNCE_EN.
- Defined: emulates contact bounce during the first 4 cycles of every press.
  - touch_out = 0,1,0,1 on PRESS cycles cnt=0..3, then 0 for cnt=4..PRESS_CYC-1.
  - Total press window stays PRESS_CYC cycles.
  - Each press then presents 3 falling edges to a non-debounced receiver.
  - PRESS_CYC < 8 is a configuration error; flag it with a simulation $error at time 0.
- Undefined: touch_out is a clean single low pulse per press; no bounce logic synthesized.

Test Plan:
- Reset: assert sys_rst_n=0 with start=1 -> touch_out=1, busy=0, done=0 throughout; release -> still idle until start.
- Single press (PRESS_CYC=4, GAP_CYC=3), start with press_num=1 -> touch_out low exactly 4 cycles then high; done pulses once 7 cycles after E0; busy high for those 7 cycles.
- Burst, press_num=3 (same params) -> three low windows of 4 cycles separated by 3-cycle highs; done at E0+21; a downstream LED toggler ends inverted from its start value.
- press_num=0 -> done high 1 cycle after start; touch_out never leaves 1; busy stays 0.
- start re-pulsed during busy, and press_num changed mid-burst -> burst unaffected; a start coincident with done launches the next burst at that edge.
- Async reset mid-PRESS -> touch_out=1 immediately (before the next clock edge); no done.
- With TOUCH_PULSE_GEN_BOUNCE_EN (PRESS_CYC=8), press_num=1 -> touch_out sequence 0,1,0,1,0,0,0,0 then 1; falling-edge count = 3.
